// File: rtl/pe_client_pkg.sv
// Shared constants for the Hoplite PE client: packet address field placement.
// The X field sits at ADDR_LSB and the Y field sits directly above it.
package pe_client_pkg;

   localparam int unsigned ADDR_LSB = 0;

endpackage

// File: rtl/pe_fifo.sv
// Circular-buffer FIFO for PE injection; DEPTH must be a power of 2 so pointers wrap naturally.
module pe_fifo #(
   parameter int unsigned W     = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] cnt_q;
   logic          do_push, do_pop;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr_q];
   assign cnt     = cnt_q;

   // Storage is not reset; occupancy alone defines what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/pe_client.sv
// PE-side Hoplite network interface: injection FIFO with grant retry, plus ejection register.
// Optional feature macro: PE_LOOPBACK_EN (self-addressed head bypasses the switch into ejection).
module pe_client
   import pe_client_pkg::*;
#(
   parameter int unsigned P_W   = 32,
   parameter int unsigned X_AW  = 2,
   parameter int unsigned Y_AW  = 2,
   parameter int unsigned X_POS = 0,
   parameter int unsigned Y_POS = 0,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [P_W-1:0]             pe_pkt,
   input  logic                       pe_vld,
   output logic                       pe_rdy,
   output logic [P_W-1:0]             sw_pkt,
   output logic                       sw_vld,
   input  logic                       sw_rdy,
   input  logic [P_W-1:0]             ej_in_pkt,
   input  logic                       ej_in_vld,
   output logic [P_W-1:0]             ej_pkt,
   output logic                       ej_vld,
   output logic [$clog2(DEPTH):0]     fifo_cnt
);

`ifdef PE_LOOPBACK_EN
   localparam logic LB_EN = 1'b1;
`else
   localparam logic LB_EN = 1'b0;
`endif

   localparam int unsigned YLSB = ADDR_LSB + X_AW;

   logic [P_W-1:0] head;
   logic           full, empty;
   logic           self_addr, lb_head, lb_pop, pop, push;
   logic [P_W-1:0] ej_pkt_q;
   logic           ej_vld_q;

   assign self_addr = (head[ADDR_LSB +: X_AW] == X_AW'(X_POS)) &&
                      (head[YLSB +: Y_AW] == Y_AW'(Y_POS));
   assign lb_head   = LB_EN & ~empty & self_addr;

   assign pe_rdy = ~full;
   assign push   = pe_vld & ~full;
   assign sw_vld = ~empty & ~lb_head;
   assign sw_pkt = sw_vld ? head : '0;
   // Network ejection has priority over the loopback path for the single ejection register.
   assign lb_pop = lb_head & ~ej_in_vld;
   assign pop    = (sw_vld & sw_rdy) | lb_pop;

   pe_fifo #(
      .W     (P_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (pe_pkt),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .cnt   (fifo_cnt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ej_pkt_q <= '0;
         ej_vld_q <= 1'b0;
      end else if (ej_in_vld) begin
         ej_pkt_q <= ej_in_pkt;
         ej_vld_q <= 1'b1;
      end else if (lb_pop) begin
         ej_pkt_q <= head;
         ej_vld_q <= 1'b1;
      end else begin
         ej_vld_q <= 1'b0;
      end
   end

   assign ej_pkt = ej_pkt_q;
   assign ej_vld = ej_vld_q;

endmodule

// File: tb/tb_pe_client.sv
// Directed, table-driven bench for pe_client (DEPTH=4, node at 0,0).
module tb_pe_client;

   localparam int unsigned P_W   = 32;
   localparam int unsigned DEPTH = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [P_W-1:0] pe_pkt;
   logic           pe_vld;
   logic           pe_rdy;
   logic [P_W-1:0] sw_pkt;
   logic           sw_vld;
   logic           sw_rdy;
   logic [P_W-1:0] ej_in_pkt;
   logic           ej_in_vld;
   logic [P_W-1:0] ej_pkt;
   logic           ej_vld;
   logic [2:0]     fifo_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pe_client #(
      .P_W   (P_W),
      .X_AW  (2),
      .Y_AW  (2),
      .X_POS (0),
      .Y_POS (0),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pe_pkt    (pe_pkt),
      .pe_vld    (pe_vld),
      .pe_rdy    (pe_rdy),
      .sw_pkt    (sw_pkt),
      .sw_vld    (sw_vld),
      .sw_rdy    (sw_rdy),
      .ej_in_pkt (ej_in_pkt),
      .ej_in_vld (ej_in_vld),
      .ej_pkt    (ej_pkt),
      .ej_vld    (ej_vld),
      .fifo_cnt  (fifo_cnt)
   );

   typedef struct {
      logic        pvld;
      logic [31:0] ppkt;
      logic        srdy;
      logic        evld;
      logic [31:0] epkt;
      logic        x_svld;
      logic [31:0] x_spkt;
      logic [2:0]  x_cnt;
      logic        x_prdy;
      logic        x_evld;
      logic [31:0] x_epkt;
   } vec_t;

   vec_t vec [31];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic pv, input logic [31:0] pp, input logic sr,
                        input logic ev, input logic [31:0] ep);
      pe_vld = pv; pe_pkt = pp; sw_rdy = sr; ej_in_vld = ev; ej_in_pkt = ep;
   endtask

   task automatic check_all(input string tag, input logic svld, input logic [31:0] spkt,
                            input logic [2:0] cnt, input logic prdy, input logic evld,
                            input logic [31:0] epkt);
      check({tag, ".sw_vld"}, 32'(sw_vld), 32'(svld));
      check({tag, ".sw_pkt"}, sw_pkt, spkt);
      check({tag, ".fifo_cnt"}, 32'(fifo_cnt), 32'(cnt));
      check({tag, ".pe_rdy"}, 32'(pe_rdy), 32'(prdy));
      check({tag, ".ej_vld"}, 32'(ej_vld), 32'(evld));
      check({tag, ".ej_pkt"}, ej_pkt, epkt);
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later, before the rise.
   task automatic step(input vec_t v, input string tag);
      @(negedge clk);
      drive(v.pvld, v.ppkt, v.srdy, v.evld, v.epkt);
      #1;
      check_all(tag, v.x_svld, v.x_spkt, v.x_cnt, v.x_prdy, v.x_evld, v.x_epkt);
   endtask

   initial begin
      // pvld ppkt srdy evld epkt | sw_vld sw_pkt cnt pe_rdy ej_vld ej_pkt
      // grant stall: A5 held for 5 cycles, then granted
      vec[0]  = '{1, 32'hA5, 0, 0, 0,   0, 0,      0, 1, 0, 0};
      vec[1]  = '{0, 0,      0, 0, 0,   1, 32'hA5, 1, 1, 0, 0};
      vec[2]  = '{0, 0,      0, 0, 0,   1, 32'hA5, 1, 1, 0, 0};
      vec[3]  = '{0, 0,      0, 0, 0,   1, 32'hA5, 1, 1, 0, 0};
      vec[4]  = '{0, 0,      0, 0, 0,   1, 32'hA5, 1, 1, 0, 0};
      vec[5]  = '{0, 0,      0, 0, 0,   1, 32'hA5, 1, 1, 0, 0};
      vec[6]  = '{0, 0,      1, 0, 0,   1, 32'hA5, 1, 1, 0, 0};
      vec[7]  = '{0, 0,      0, 0, 0,   0, 0,      0, 1, 0, 0};
      // full: 1..4 queued, 5 ignored, 9 ignored while full-and-popping, order kept
      vec[8]  = '{1, 32'h01, 0, 0, 0,   0, 0,      0, 1, 0, 0};
      vec[9]  = '{1, 32'h02, 0, 0, 0,   1, 32'h01, 1, 1, 0, 0};
      vec[10] = '{1, 32'h03, 0, 0, 0,   1, 32'h01, 2, 1, 0, 0};
      vec[11] = '{1, 32'h04, 0, 0, 0,   1, 32'h01, 3, 1, 0, 0};
      vec[12] = '{1, 32'h05, 0, 0, 0,   1, 32'h01, 4, 0, 0, 0};
      vec[13] = '{1, 32'h09, 1, 0, 0,   1, 32'h01, 4, 0, 0, 0};
      vec[14] = '{0, 0,      0, 0, 0,   1, 32'h02, 3, 1, 0, 0};
      vec[15] = '{0, 0,      1, 0, 0,   1, 32'h02, 3, 1, 0, 0};
      vec[16] = '{0, 0,      1, 0, 0,   1, 32'h03, 2, 1, 0, 0};
      vec[17] = '{0, 0,      1, 0, 0,   1, 32'h04, 1, 1, 0, 0};
      vec[18] = '{0, 0,      0, 0, 0,   0, 0,      0, 1, 0, 0};
      // simultaneous push + pop at count 2
      vec[19] = '{1, 32'h06, 0, 0, 0,   0, 0,      0, 1, 0, 0};
      vec[20] = '{1, 32'h07, 0, 0, 0,   1, 32'h06, 1, 1, 0, 0};
      vec[21] = '{1, 32'h08, 1, 0, 0,   1, 32'h06, 2, 1, 0, 0};
      vec[22] = '{0, 0,      0, 0, 0,   1, 32'h07, 2, 1, 0, 0};
      vec[23] = '{0, 0,      1, 0, 0,   1, 32'h07, 2, 1, 0, 0};
      vec[24] = '{0, 0,      1, 0, 0,   1, 32'h08, 1, 1, 0, 0};
      vec[25] = '{0, 0,      0, 0, 0,   0, 0,      0, 1, 0, 0};
      // ejection: three back-to-back pulses, one-cycle delay, pkt holds afterwards
      vec[26] = '{0, 0,      0, 1, 32'h11, 0, 0,   0, 1, 0, 0};
      vec[27] = '{0, 0,      0, 1, 32'h22, 0, 0,   0, 1, 1, 32'h11};
      vec[28] = '{0, 0,      0, 1, 32'h33, 0, 0,   0, 1, 1, 32'h22};
      vec[29] = '{0, 0,      0, 0, 0,   0, 0,      0, 1, 1, 32'h33};
      vec[30] = '{0, 0,      0, 0, 0,   0, 0,      0, 1, 0, 32'h33};

      drive(0, 0, 0, 0, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_all("reset", 0, 0, 0, 1, 0, 0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 31; i++) step(vec[i], $sformatf("vec%0d", i));

      // reset mid-traffic: 3 queued and an ejection in flight
      @(negedge clk); drive(1, 32'h41, 0, 0, 0);
      @(negedge clk); drive(1, 32'h42, 0, 0, 0);
      @(negedge clk); drive(1, 32'h43, 0, 1, 32'h77);
      @(negedge clk); drive(0, 0, 0, 0, 0);
      #1;
      check("pre_rst.fifo_cnt", 32'(fifo_cnt), 32'd3);
      check("pre_rst.ej_vld", 32'(ej_vld), 32'd1);
      #1 rst = 1'b0;
      #1;
      check_all("mid_rst", 0, 0, 0, 1, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_all("post_rst", 0, 0, 0, 1, 0, 0);

`ifdef PE_LOOPBACK_EN
      // self-addressed 0x50 (x=0,y=0) waits behind two network ejections
      @(negedge clk); drive(1, 32'h50, 0, 0, 0);
      @(negedge clk); drive(0, 0, 1, 1, 32'hC1);
      #1 check_all("lb0", 0, 0, 1, 1, 0, 0);
      @(negedge clk); drive(0, 0, 1, 1, 32'hC2);
      #1 check_all("lb1", 0, 0, 1, 1, 1, 32'hC1);
      @(negedge clk); drive(0, 0, 1, 0, 0);
      #1 check_all("lb2", 0, 0, 1, 1, 1, 32'hC2);
      @(negedge clk); drive(0, 0, 0, 0, 0);
      #1 check_all("lb3", 0, 0, 0, 1, 1, 32'h50);
      @(negedge clk);
      #1 check_all("lb4", 0, 0, 0, 1, 0, 32'h50);
`else
      // self-addressed packet still goes to the switch
      @(negedge clk); drive(1, 32'h50, 0, 0, 0);
      @(negedge clk); drive(0, 0, 1, 0, 0);
      #1 check_all("self0", 1, 32'h50, 1, 1, 0, 0);
      @(negedge clk); drive(0, 0, 0, 0, 0);
      #1 check_all("self1", 0, 0, 0, 1, 0, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
